mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; no other value is supported.
REQ-002 Clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state.
REQ-004 start  in  1  request pulse; sampled only in IDLE.
REQ-005 op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 oper_A  in  32  multiplicand / dividend.
REQ-007 oper_B  in  32  multiplier / divisor.
REQ-008 hi  out  32  product high word / remainder.
REQ-009 lo  out  32  product low word / quotient.
REQ-010 busy  out  1  high while an operation is in progress.
REQ-011 done  out  1  single-cycle result-valid pulse.
REQ-012 div_zero  out  1  divide-by-zero flag for the most recent operation.

Function
REQ-013 FSM states: IDLE, RUN, FIX, DONE; IDLE is the reset state.
REQ-014 IDLE plus start=1: capture op, oper_A, oper_B at edge E0 and go to RUN; later operand changes have no effect.
REQ-015 start while in RUN, FIX or DONE is ignored; no queuing.
REQ-016 Signed ops (MULT, DIV) use operand magnitudes internally; operand signs are recorded at E0.
REQ-017 RUN: 32 iterations, one per cycle, 5-bit down-counter loaded with 31 at E0; exit to FIX when the counter reaches 0.
REQ-018 Multiply: shift-add over magnitudes; 64-bit unsigned product {hi,lo}.
REQ-019 Divide: restoring division over magnitudes; quotient to lo, remainder to hi.
REQ-020 FIX (one cycle): negate the product when operand signs differ (signed only); negate the quotient when signs differ; give the remainder the dividend's sign (truncation toward zero).
REQ-021 DIV 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0; no overflow flag exists.
REQ-022 hi/lo update and done=1 at edge E0+33 (enter DONE); return to IDLE at E0+34, done=0.
REQ-023 busy=1 exactly in RUN and FIX (cycles E0..E0+33); busy=0 in IDLE and DONE.
REQ-024 Divide with captured oper_B=0: skip RUN/FIX; at E0+1 enter DONE with hi=oper_A, lo=0xFFFFFFFF, div_zero=1.
REQ-025 div_zero is cleared at the E0 of every accepted start and otherwise holds its value.
REQ-026 hi/lo hold their values between operations; they change only on entry to DONE.
REQ-027 MULT/MULTU with operand 0 still take the full 33 cycles (fixed latency).

Reset
REQ-028 When reset is asserted, state=IDLE and hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0, independent of Clk.
REQ-029 Reset during RUN/FIX/DONE aborts the operation; no partial result is ever driven to hi/lo.
REQ-030 start coincident with reset deassertion is honoured only on a subsequent edge where reset=0.

Structure
REQ-031 The op encoding enum, the FSM state enum and the constants WIDTH=32 and ITER=32 reside in the shared package mips_pkg.
REQ-032 One combinational sub-module, mdu_sign_fix (conditional 32/64-bit two's-complement negate), serves REQ-016 and REQ-020.
REQ-033 All other logic (FSM, counter, shift datapath) resides in mult_div_unit.

Verification
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done at E0+33, busy high E0..E0+33.
REQ-035 MULT 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-036 DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
REQ-037 DIVU 7 / 0 -> done at E0+1, hi=7, lo=0xFFFFFFFF, div_zero=1; next MULTU 2x3 -> div_zero=0, lo=6.
REQ-038 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 start re-pulsed at E0+5 is ignored (single done at E0+33); reset at E0+10 -> all outputs 0, IDLE, no done pulse.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Holds the op encoding, the controller state encoding and the fixed width and iteration count.
package mips_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate. The unit uses it for operand magnitudes
// and for the sign correction of the product, quotient and remainder.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = neg ? (~din + {{(W-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply and restoring divide over
// operand magnitudes, 32 iterations, then one sign-fix cycle before the result is presented.
module mult_div_unit #(
    parameter int WIDTH = mips_pkg::WIDTH
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] oper_A,
    input  logic [WIDTH-1:0] oper_B,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    import mips_pkg::*;

    localparam logic [4:0] CNT_LOAD = 5'(ITER - 1);

    state_e             state_r;
    logic [4:0]         cnt_r;
    logic [WIDTH-1:0]   acc_hi_r;
    logic [WIDTH-1:0]   acc_lo_r;
    logic [WIDTH-1:0]   divisor_r;
    logic               is_div_r;
    logic               sa_r;
    logic               sb_r;
    logic               dz_r;

    logic               signed_s;
    logic               div_s;
    logic               neg_a_s;
    logic               neg_b_s;
    logic               dz_start_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     shl_s;
    logic [WIDTH:0]     sub_s;
    logic [WIDTH-1:0]   nxt_hi_s;
    logic [WIDTH-1:0]   nxt_lo_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    assign signed_s   = (op == OP_MULT) || (op == OP_DIV);
    assign div_s      = (op == OP_DIV)  || (op == OP_DIVU);
    assign neg_a_s    = signed_s & oper_A[WIDTH-1];
    assign neg_b_s    = signed_s & oper_B[WIDTH-1];
    assign dz_start_s = div_s & (oper_B == {WIDTH{1'b0}});

    mdu_sign_fix #(.W(WIDTH)) u_mag_a (.neg(neg_a_s), .din(oper_A), .dout(mag_a_s));
    mdu_sign_fix #(.W(WIDTH)) u_mag_b (.neg(neg_b_s), .din(oper_B), .dout(mag_b_s));

    // Remainder takes the dividend's sign so that division truncates toward zero.
    mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (.neg(sa_r ^ sb_r), .din({acc_hi_r, acc_lo_r}), .dout(prod_fix_s));
    mdu_sign_fix #(.W(WIDTH))   u_fix_quo  (.neg(sa_r ^ sb_r), .din(acc_lo_r), .dout(quo_fix_s));
    mdu_sign_fix #(.W(WIDTH))   u_fix_rem  (.neg(sa_r),        .din(acc_hi_r), .dout(rem_fix_s));

    // One iteration of the shared shift datapath (multiply: acc_lo holds multiplier; divide: quotient).
    always_comb begin
        add_s    = {1'b0, acc_hi_r} + {1'b0, divisor_r};
        shl_s    = {acc_hi_r, acc_lo_r[WIDTH-1]};
        sub_s    = shl_s - {1'b0, divisor_r};
        nxt_hi_s = acc_hi_r;
        nxt_lo_s = acc_lo_r;
        if (is_div_r) begin
            if (!sub_s[WIDTH]) begin
                nxt_hi_s = sub_s[WIDTH-1:0];
                nxt_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi_s = shl_s[WIDTH-1:0];
                nxt_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc_lo_r[0]) begin
                {nxt_hi_s, nxt_lo_s} = {add_s, acc_lo_r[WIDTH-1:1]};
            end else begin
                {nxt_hi_s, nxt_lo_s} = {1'b0, acc_hi_r, acc_lo_r[WIDTH-1:1]};
            end
        end
    end

    // Controller, iteration counter, working registers and registered outputs.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            cnt_r     <= 5'd0;
            acc_hi_r  <= {WIDTH{1'b0}};
            acc_lo_r  <= {WIDTH{1'b0}};
            divisor_r <= {WIDTH{1'b0}};
            is_div_r  <= 1'b0;
            sa_r      <= 1'b0;
            sb_r      <= 1'b0;
            dz_r      <= 1'b0;
            hi        <= {WIDTH{1'b0}};
            lo        <= {WIDTH{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        is_div_r  <= div_s;
                        sa_r      <= neg_a_s;
                        sb_r      <= neg_b_s;
                        dz_r      <= dz_start_s;
                        divisor_r <= mag_b_s;
                        acc_hi_r  <= {WIDTH{1'b0}};
                        // A zero divisor bypasses the iterations; keep the raw dividend for hi.
                        acc_lo_r  <= dz_start_s ? oper_A : mag_a_s;
                        cnt_r     <= CNT_LOAD;
                        div_zero  <= 1'b0;
                        busy      <= 1'b1;
                        state_r   <= dz_start_s ? S_FIX : S_RUN;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc_hi_r <= nxt_hi_s;
                    acc_lo_r <= nxt_lo_s;
                    if (cnt_r == 5'd0) begin
                        state_r <= S_FIX;
                    end else begin
                        cnt_r <= cnt_r - 5'd1;
                    end
                end
                S_FIX: begin
                    if (dz_r) begin
                        hi       <= acc_lo_r;
                        lo       <= {WIDTH{1'b1}};
                        div_zero <= 1'b1;
                    end else if (is_div_r) begin
                        hi <= rem_fix_s;
                        lo <= quo_fix_s;
                    end else begin
                        {hi, lo} <= prod_fix_s;
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_r <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
